// File: rtl/pong_pkg.sv
// Shared encodings, geometry constants and the clamped step helper for the paddle controllers.
package pong_pkg;

  localparam int unsigned FIELD_H     = 480;
  localparam int unsigned PADDLE_H    = 64;
  localparam int unsigned Y_W         = 10;
  localparam int unsigned STEP        = 4;
  localparam int unsigned REPEAT_DLY  = 25;
  localparam int unsigned REPEAT_PER  = 5;
  localparam int unsigned ACCEL_AFTER = 8;

  localparam int unsigned Y_MAX    = FIELD_H - PADDLE_H;
  localparam int unsigned Y_CENTER = Y_MAX / 2;
  localparam int unsigned CNT_W    = $clog2(REPEAT_DLY);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} axis_state_e;
  typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

  function automatic dir_e decode_dir(input logic up, input logic down);
    if (up && !down) return DirUp;
    if (down && !up) return DirDown;
    return DirNone;
  endfunction

  // One extra bit of headroom so neither direction can wrap before clamping.
  function automatic logic [Y_W-1:0] clamp_step(input logic [Y_W-1:0] y, input dir_e dir,
                                                input logic [Y_W:0] step);
    logic [Y_W:0] ext;
    logic [Y_W:0] res;
    ext = {1'b0, y};
    res = ext;
    if (dir == DirUp) begin
      res = (ext < step) ? '0 : ext - step;
    end else if (dir == DirDown) begin
      res = ext + step;
      if (res > (Y_W+1)'(Y_MAX)) res = (Y_W+1)'(Y_MAX);
    end
    return Y_W'(res);
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// Press/hold auto-repeat FSM and clamped position register for a single paddle.
// Optional PADDLE_ACCEL_EN doubles the step after ACCEL_AFTER auto-repeat steps.
module paddle_axis
  import pong_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           center,
  input  logic           up,
  input  logic           down,
  output logic [Y_W-1:0] y,
  output logic           moving
);

  axis_state_e      state;
  dir_e             dir;
  dir_e             dir_lat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             timer_hit;
  logic [Y_W:0]     step_sz;

  always_comb begin
    dir       = decode_dir(up, down);
    limit     = (state == StRepeat) ? CNT_W'(REPEAT_PER - 1) : CNT_W'(REPEAT_DLY - 1);
    timer_hit = (cnt == limit);
  end

`ifdef PADDLE_ACCEL_EN
  localparam int unsigned RPT_W = $clog2(ACCEL_AFTER + 1);
  logic [RPT_W-1:0] rpt_cnt;

  // Counts timer-driven steps only; any break in the same-direction hold clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else if (center || !en || dir == DirNone || state == StIdle || dir != dir_lat) begin
      rpt_cnt <= '0;
    end else if (timer_hit && rpt_cnt != RPT_W'(ACCEL_AFTER)) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  assign step_sz = (rpt_cnt == RPT_W'(ACCEL_AFTER)) ? (Y_W+1)'(2 * STEP) : (Y_W+1)'(STEP);
`else
  assign step_sz = (Y_W+1)'(STEP);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= Y_W'(Y_CENTER);
      state   <= StIdle;
      cnt     <= '0;
      dir_lat <= DirNone;
      moving  <= 1'b0;
    end else if (center) begin
      y      <= Y_W'(Y_CENTER);
      state  <= StIdle;
      cnt    <= '0;
      moving <= 1'b0;
    end else if (!en || dir == DirNone) begin
      state  <= StIdle;
      cnt    <= '0;
      moving <= 1'b0;
    end else begin
      moving <= 1'b1;
      case (state)
        StIdle: begin
          y       <= clamp_step(y, dir, step_sz);
          dir_lat <= dir;
          cnt     <= '0;
          state   <= StDelay;
        end
        default: begin
          if (dir != dir_lat) begin
            y       <= clamp_step(y, dir, step_sz);
            dir_lat <= dir;
            cnt     <= '0;
            state   <= StDelay;
          end else if (timer_hit) begin
            y     <= clamp_step(y, dir, step_sz);
            cnt   <= '0;
            state <= StRepeat;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_position_ctrl.sv
// Two independent paddle axes sharing enable and re-centre; keypad levels in, clamped y out.
// Build option: PADDLE_ACCEL_EN enables step acceleration during long holds.
module paddle_position_ctrl
  import pong_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           center,
  input  logic           up1,
  input  logic           down1,
  input  logic           up2,
  input  logic           down2,
  output logic [Y_W-1:0] paddle1_y,
  output logic [Y_W-1:0] paddle2_y,
  output logic           moving1,
  output logic           moving2
);

  paddle_axis u_axis1 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .center (center),
    .up     (up1),
    .down   (down1),
    .y      (paddle1_y),
    .moving (moving1)
  );

  paddle_axis u_axis2 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .center (center),
    .up     (up2),
    .down   (down2),
    .y      (paddle2_y),
    .moving (moving2)
  );

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Scoreboard bench: a hold-time reference model predicts both paddles every cycle.
module tb_paddle_position_ctrl;

  localparam int YC  = 208;
  localparam int YM  = 416;
  localparam int STP = 4;
  localparam int DLY = 25;
  localparam int PER = 5;
  localparam int ACC = 8;

  logic       clk = 1'b0;
  logic       rst, en, center, up1, down1, up2, down2;
  logic [9:0] paddle1_y, paddle2_y;
  logic       moving1, moving2;

  always #5 clk = ~clk;

  paddle_position_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .center    (center),
    .up1       (up1),
    .down1     (down1),
    .up2       (up2),
    .down2     (down2),
    .paddle1_y (paddle1_y),
    .paddle2_y (paddle2_y),
    .moving1   (moving1),
    .moving2   (moving2)
  );

  typedef struct {
    int y1;
    int y2;
    int m1;
    int m2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   my[2];
  int   mt[2];
  int   mdir[2];

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dir_of(input logic u, input logic d);
    if (u && !d) return 1;
    if (d && !u) return 2;
    return 0;
  endfunction

  // t = cycles since the current same-direction hold began.
  function automatic bit is_step(input int t);
    return t == 0 || t == DLY || (t > DLY && (t - DLY) % PER == 0);
  endfunction

  function automatic int step_size(input int t);
`ifdef PADDLE_ACCEL_EN
    if (t >= DLY && (t - DLY) / PER >= ACC) return 2 * STP;
`endif
    return STP;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      my[p]   = YC;
      mt[p]   = -1;
      mdir[p] = 0;
    end
  endtask

  task automatic model_player(input int p, input int d, output int mv);
    int sz;
    if (center) begin
      my[p] = YC;
      mt[p] = -1;
      mv    = 0;
    end else if (!en || d == 0) begin
      mt[p] = -1;
      mv    = 0;
    end else begin
      if (mt[p] < 0 || d != mdir[p]) mt[p] = 0;
      else mt[p]++;
      mdir[p] = d;
      sz = step_size(mt[p]);
      if (is_step(mt[p])) begin
        if (d == 1) my[p] = (my[p] < sz) ? 0 : my[p] - sz;
        else        my[p] = (my[p] + sz > YM) ? YM : my[p] + sz;
      end
      mv = 1;
    end
  endtask

  task automatic cycle(input logic u1, input logic d1, input logic u2, input logic d2,
                       input logic e, input logic c);
    exp_t x;
    int   m1v, m2v;
    @(negedge clk);
    up1 = u1; down1 = d1; up2 = u2; down2 = d2; en = e; center = c;
    model_player(0, dir_of(u1, d1), m1v);
    model_player(1, dir_of(u2, d2), m2v);
    x.y1 = my[0]; x.y2 = my[1]; x.m1 = m1v; x.m2 = m2v;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 0, 1);
    end else begin
      x = sb.pop_front();
      check_val("sb_y1", int'(paddle1_y), x.y1);
      check_val("sb_y2", int'(paddle2_y), x.y2);
      check_val("sb_moving1", int'(moving1), x.m1);
      check_val("sb_moving2", int'(moving2), x.m2);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; center = 1'b0;
    up1 = 1'b0; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
    model_reset();
    #12;
    check_val("rst_y1", int'(paddle1_y), YC);
    check_val("rst_y2", int'(paddle2_y), YC);
    check_val("rst_moving1", int'(moving1), 0);
    check_val("rst_moving2", int'(moving2), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single tap.
    cycle(1, 0, 0, 0, 1, 0);
    check_val("tap_y1", int'(paddle1_y), 204);
    check_val("tap_y2", int'(paddle2_y), YC);
    cycle(0, 0, 0, 0, 1, 0);
    check_val("tap_idle", int'(moving1), 0);

    // 40-cycle hold from centre: steps at 0, 25, 30, 35.
    cycle(0, 0, 0, 0, 1, 1);
    repeat (40) cycle(0, 1, 0, 0, 1, 0);
    check_val("hold40_y1", int'(paddle1_y), 224);
    check_val("hold40_moving1", int'(moving1), 1);
    cycle(0, 0, 0, 0, 1, 0);
    check_val("release_moving1", int'(moving1), 0);

    // Clamp at both ends.
    repeat (500) cycle(0, 0, 1, 0, 1, 0);
    check_val("top_clamp_y2", int'(paddle2_y), 0);
    repeat (600) cycle(0, 0, 0, 1, 1, 0);
    check_val("bottom_clamp_y2", int'(paddle2_y), YM);

    // Both keys together, centre mid-hold, enable freeze.
    repeat (20) cycle(0, 0, 1, 1, 1, 0);
    check_val("both_keys_y2", int'(paddle2_y), YM);
    repeat (10) cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 1, 1);
    check_val("center_y1", int'(paddle1_y), YC);
    check_val("center_y2", int'(paddle2_y), YC);
    repeat (5) cycle(0, 1, 0, 0, 1, 0);
    repeat (10) cycle(0, 1, 0, 0, 0, 0);
    check_val("en0_frozen_y1", int'(paddle1_y), 212);
    cycle(0, 1, 0, 0, 1, 0);
    check_val("en_return_y1", int'(paddle1_y), 216);

    // Acceleration boundary: the 9th auto-repeat step.
    cycle(0, 0, 0, 0, 1, 1);
    repeat (66) cycle(0, 1, 0, 0, 1, 0);
`ifdef PADDLE_ACCEL_EN
    check_val("accel_y1", int'(paddle1_y), 252);
`else
    check_val("accel_y1", int'(paddle1_y), 248);
`endif

    // Randomised segments of held keys.
    for (int s = 0; s < 40; s++) begin
      logic [3:0] k;
      logic       e;
      int         len;
      k   = 4'($urandom);
      e   = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++)
        cycle(k[0], k[1], k[2], k[3], e, ($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset mid-hold.
    cycle(0, 0, 0, 0, 1, 1);
    repeat (30) cycle(0, 1, 1, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_y1", int'(paddle1_y), YC);
    check_val("async_rst_y2", int'(paddle2_y), YC);
    check_val("async_rst_moving1", int'(moving1), 0);
    check_val("async_rst_moving2", int'(moving2), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(0, 1, 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
